// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide unit: shift-and-add multiply, restoring
// divide, one step per clock, fixed 33-cycle latency from accept to result.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic            neg_q;      // product / quotient must be negated
  logic            rneg_q;     // remainder takes a negative dividend's sign
  logic [W-1:0]    acc_hi;     // product high half, or partial remainder
  logic [W-1:0]    acc_lo;     // multiplier / product low half, or dividend / quotient
  logic [W-1:0]    opb;        // multiplicand magnitude, or divisor magnitude

  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [W:0]      mul_sum;
  logic [W:0]      shifted;
  logic [W+1:0]    sub_res;
  logic            no_borrow;
  logic [W-1:0]    step_hi;
  logic [W-1:0]    step_lo;
  logic [2*W-1:0]  prod;
  logic [2*W-1:0]  prod_neg;
  logic [W-1:0]    fix_hi;
  logic [W-1:0]    fix_lo;
  logic            fix_dz;

  // Operand magnitudes, one iteration step, and the final sign/special-case fixup
  always_comb begin
    a_mag     = (op[0] && a[W-1]) ? W'(~a) + W'(1) : a;
    b_mag     = (op[0] && b[W-1]) ? W'(~b) + W'(1) : b;
    mul_sum   = {1'b0, acc_hi} + {1'b0, opb};
    shifted   = {acc_hi, acc_lo[W-1]};
    // ALU subtract form: carry out set means no borrow
    sub_res   = {1'b0, shifted} + {1'b0, ~{1'b0, opb}} + (W+2)'(1);
    no_borrow = sub_res[W+1];
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    if (!op_q[1]) begin
      if (acc_lo[0]) {step_hi, step_lo} = {mul_sum, acc_lo[W-1:1]};
      else           {step_hi, step_lo} = {1'b0, acc_hi, acc_lo[W-1:1]};
    end else begin
      step_hi = no_borrow ? sub_res[W-1:0] : shifted[W-1:0];
      step_lo = {acc_lo[W-2:0], no_borrow};
    end

    prod     = {acc_hi, acc_lo};
    prod_neg = (2*W)'(~prod) + (2*W)'(1);
    fix_dz   = 1'b0;
    case (op_q)
      2'b00:   {fix_hi, fix_lo} = prod;
      2'b01:   {fix_hi, fix_lo} = neg_q ? prod_neg : prod;
      2'b10: begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
      end
      default: begin
        fix_hi = rneg_q ? W'(~acc_hi) + W'(1) : acc_hi;
        fix_lo = neg_q  ? W'(~acc_lo) + W'(1) : acc_lo;
      end
    endcase
    // Divide by zero: remainder already equals the original dividend
    if (op_q[1] && (opb == W'(0))) begin
      fix_lo = '1;
      fix_dz = 1'b1;
    end
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opb       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= op;
            neg_q    <= op[0] & (a[W-1] ^ b[W-1]);
            rneg_q   <= op[0] & a[W-1];
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            opb      <= b_mag;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          hi        <= fix_hi;
          lo        <= fix_lo;
          div_zero  <= fix_dz;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model, per-cycle
// output compare, directed vectors with hand-computed results.
module tb_muldiv_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int          checks;
  int          failures;
  logic [64:0] exp_res;
  logic        pending;

  muldiv_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: {div_zero, hi, lo} from plain integer arithmetic
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint p;
    int     sx;
    int     sy;
    sx = int'(x);
    sy = int'(y);
    case (o)
      2'd0: return {1'b0, 64'(x) * 64'(y)};
      2'd1: begin
        p = longint'(sx) * longint'(sy);
        return {1'b0, 64'(p)};
      end
      2'd2: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
      default: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        return {1'b0, 32'(sx % sy), 32'(sx / sy)};
      end
    endcase
  endfunction

  // Result values must match the model every cycle out_valid is high
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (!pending) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=1 required=0");
      end else begin
        check("result", {div_zero, hi, lo}, exp_res);
        check("in_ready_during_done", 65'(in_ready), 65'(0));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [64:0] hand, input int hold);
    int   k;
    int   lat;
    logic busy_rdy;
    logic held;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_accept", 65'(in_ready), 65'(1));
    check("model_vs_hand", model(o, x, y), hand);
    exp_res   = model(o, x, y);
    pending   = 1'b1;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op       = 2'($urandom);
    lat      = 0;
    busy_rdy = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
      if (in_ready) busy_rdy = 1'b1;
    end
    check("latency", 65'(lat), 65'(33));
    check("in_ready_while_busy", 65'(busy_rdy), 65'(0));
    if (lat == 0) begin
      pending   = 1'b0;
      out_ready = 1'b1;
      return;
    end
    if (hold > 0) begin
      held = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!out_valid) held = 1'b0;
      end
      check("out_valid_held", 65'(held), 65'(1));
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid_after_hs", 65'(out_valid), 65'(0));
    check("in_ready_after_hs", 65'(in_ready), 65'(1));
    pending = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pending   = 1'b0;
    exp_res   = '0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 2'd0;
    a         = 32'd0;
    b         = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {61'(0), in_ready, out_valid, div_zero, |{hi, lo}},
          {61'(0), 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    reset_n = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, 0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, 0);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7,         {1'b0, 32'h0000_0006, 32'hFFFF_FFEB}, 0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0000_0000, 32'h8000_0000}, 0);
    run_op(2'd2, 32'd100,       32'd0,         {1'b1, 32'd100,       32'hFFFF_FFFF}, 0);
    run_op(2'd2, 32'd100,       32'd7,         {1'b0, 32'd2,         32'd14}, 0);
    run_op(2'd3, 32'd7,         32'hFFFF_FFFE, {1'b0, 32'd1,         32'hFFFF_FFFD}, 0);
    run_op(2'd3, 32'hFFFF_FFFB, 32'd0,         {1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0);
    run_op(2'd1, 32'h1234_5678, 32'hFFFF_FFFE, {1'b0, 32'hFFFF_FFFF, 32'hDB97_5310}, 10);

    // Reset asserted mid-cycle during a divide discards it at once
    @(negedge clk);
    check("in_ready_before_reset_op", 65'(in_ready), 65'(1));
    in_valid = 1'b1;
    op       = 2'd2;
    a        = 32'd1000;
    b        = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {61'(0), in_ready, out_valid, div_zero, |{hi, lo}},
          {61'(0), 1'b1, 1'b0, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", 65'(in_ready), 65'(1));
    run_op(2'd0, 32'd6, 32'd7, {1'b0, 32'd0, 32'd42}, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
